// File: rtl/hl_reset_sequencer.sv
// hl_reset_sequencer: board-level reset sequencer for Hermes Lite wrappers.
// Qualifies the PLL lock flags, releases NDOM active-low domain resets in
// index order spaced STAGE_CYCLES apart, and re-asserts every reset on lock
// loss or on a host soft-reset request. Lock-loss events are counted.
// Optional watchdog: define HL_RESET_WDOG_EN to build it.
module hl_reset_sequencer #(
    parameter int unsigned NDOM         = 4,
    parameter int unsigned NLOCK        = 1,
    parameter int unsigned LOCK_FILTER  = 16,
    parameter int unsigned STAGE_CYCLES = 1024,
    parameter int unsigned WDOG_CYCLES  = 2**20
) (
    input  logic             clk,
    input  logic             extreset,
    input  logic [NLOCK-1:0] pll_locked,
    input  logic             sw_reset_req,
    input  logic             wdog_kick,
    output logic [NDOM-1:0]  rst_n_out,
    output logic             all_ready,
    output logic [1:0]       seq_state,
    output logic [7:0]       lock_lost_count,
    output logic             wdog_fired
);

    localparam int unsigned FW = $clog2(LOCK_FILTER + 1);
    localparam int unsigned SW = $clog2(STAGE_CYCLES);
    localparam int unsigned IW = (NDOM > 1) ? $clog2(NDOM) : 1;

    localparam logic [FW-1:0] FILT_DONE  = FW'(LOCK_FILTER);
    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDOM - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_RELEASE   = 2'd1,
        ST_RUN       = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [NLOCK-1:0] sync1_q, sync2_q;
    logic             lock_ok;
    logic [FW-1:0]    filt_q, filt_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [NDOM-1:0]  rst_q, rst_d;
    logic             ready_q, ready_d;
    logic [7:0]       cnt_q, cnt_d;

`ifdef HL_RESET_WDOG_EN
    localparam int unsigned WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [WW-1:0] wdog_q, wdog_d;
    logic          fired_q, fired_d;
    logic          wdog_expire;

    assign wdog_expire = (state_q == ST_RUN) && !wdog_kick &&
                         (wdog_q == WW'(WDOG_CYCLES - 1));
    assign wdog_fired  = fired_q;
`else
    localparam int unsigned UNUSED_WDOG_CYCLES = WDOG_CYCLES;

    logic unused_wdog_kick;

    assign unused_wdog_kick = wdog_kick;
    assign wdog_fired       = 1'b0;
`endif

    assign lock_ok         = &sync2_q;
    assign rst_n_out       = rst_q;
    assign all_ready       = ready_q;
    assign seq_state       = state_q;
    assign lock_lost_count = cnt_q;

    // Two-flop synchronizer for each raw PLL lock flag.
    always_ff @(posedge clk or negedge extreset) begin
        if (!extreset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or negedge extreset) begin
        if (!extreset) begin
            state_q <= ST_WAIT_LOCK;
            filt_q  <= '0;
            stage_q <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            stage_q <= stage_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HL_RESET_WDOG_EN
    // Watchdog counter and sticky expiry flag.
    always_ff @(posedge clk or negedge extreset) begin
        if (!extreset) begin
            wdog_q  <= '0;
            fired_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            fired_q <= fired_d;
        end
    end
`endif

    // Next-state logic; lock loss outranks soft reset, which outranks the watchdog.
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        stage_d = stage_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        cnt_d   = cnt_q;
`ifdef HL_RESET_WDOG_EN
        fired_d = fired_q;
`endif
        unique case (state_q)
            ST_WAIT_LOCK: begin
                rst_d = '0;
                if (!lock_ok || sw_reset_req) begin
                    filt_d = '0;
                end else if (filt_q == FILT_DONE) begin
                    state_d = ST_RELEASE;
                    filt_d  = '0;
                    stage_d = '0;
                    idx_d   = '0;
                end else begin
                    filt_d = filt_q + 1'b1;
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (!lock_ok) begin
                    state_d = ST_WAIT_LOCK;
                    rst_d   = '0;
                    filt_d  = '0;
                    stage_d = '0;
                    idx_d   = '0;
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end else if (sw_reset_req) begin
                    state_d = ST_DRAIN;
                    rst_d   = '0;
                    stage_d = '0;
                    idx_d   = '0;
`ifdef HL_RESET_WDOG_EN
                end else if (wdog_expire) begin
                    state_d = ST_DRAIN;
                    rst_d   = '0;
                    stage_d = '0;
                    idx_d   = '0;
                    fired_d = 1'b1;
`endif
                end else if (state_q == ST_RUN) begin
                    rst_d = '1;
                end else if (stage_q == STAGE_LAST) begin
                    stage_d      = '0;
                    rst_d[idx_q] = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                rst_d = '0;
                if (!lock_ok) begin
                    state_d = ST_WAIT_LOCK;
                    stage_d = '0;
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end else if (stage_q == STAGE_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    stage_d = '0;
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                rst_d   = '0;
            end
        endcase

        // all_ready drops on the edge that leaves RUN but rises one cycle after entry.
        ready_d = (state_q == ST_RUN) && (state_d == ST_RUN);

`ifdef HL_RESET_WDOG_EN
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            wdog_d = wdog_kick ? '0 : wdog_q + 1'b1;
        end else begin
            wdog_d = '0;
        end
`endif
    end

endmodule

// File: tb/tb_hl_reset_sequencer.sv
// Self-checking bench for hl_reset_sequencer with NDOM=4, NLOCK=2,
// LOCK_FILTER=4, STAGE_CYCLES=8, WDOG_CYCLES=64.
module tb_hl_reset_sequencer;

    logic       clk = 1'b0;
    logic       extreset;
    logic [1:0] pll_locked;
    logic       sw_reset_req;
    logic       wdog_kick;
    logic [3:0] rst_n_out;
    logic       all_ready;
    logic [1:0] seq_state;
    logic [7:0] lock_lost_count;
    logic       wdog_fired;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [3:0] rst;
        logic       rdy;
        logic [1:0] st;
        logic [7:0] cnt;
        logic       wf;
        string      name;
    } exp_t;

    exp_t sbq[$];
    exp_t em;

    hl_reset_sequencer #(
        .NDOM        (4),
        .NLOCK       (2),
        .LOCK_FILTER (4),
        .STAGE_CYCLES(8),
        .WDOG_CYCLES (64)
    ) dut (
        .clk            (clk),
        .extreset       (extreset),
        .pll_locked     (pll_locked),
        .sw_reset_req   (sw_reset_req),
        .wdog_kick      (wdog_kick),
        .rst_n_out      (rst_n_out),
        .all_ready      (all_ready),
        .seq_state      (seq_state),
        .lock_lost_count(lock_lost_count),
        .wdog_fired     (wdog_fired)
    );

    always #5 clk = ~clk;

    // Edge counter: at a falling edge, cyc is the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due at this cycle and compare.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            em = sbq.pop_front();
            checks++;
            if (em.cyc != cyc || rst_n_out !== em.rst || all_ready !== em.rdy ||
                seq_state !== em.st || lock_lost_count !== em.cnt || wdog_fired !== em.wf) begin
                failures++;
                $display("FAIL %s @%0d (due %0d): got rst=%b rdy=%b st=%0d cnt=%0d wf=%b, need rst=%b rdy=%b st=%0d cnt=%0d wf=%b",
                         em.name, cyc, em.cyc, rst_n_out, all_ready, seq_state, lock_lost_count,
                         wdog_fired, em.rst, em.rdy, em.st, em.cnt, em.wf);
            end
        end
    end

    task automatic push(input int c, input logic [3:0] r, input logic rdy,
                        input logic [1:0] st, input logic [7:0] cnt, input string nm,
                        input logic wf = 1'b0);
        exp_t e;
        e.cyc = c; e.rst = r; e.rdy = rdy; e.st = st; e.cnt = cnt; e.wf = wf; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int b;
        int c;
        int d;
        int e;

        extreset     = 1'b0;
        pll_locked   = 2'b00;
        sw_reset_req = 1'b0;
        wdog_kick    = 1'b0;

        // Reset state
        step(1);
        push(cyc + 1, 4'b0000, 0, 0, 0, "reset");
        step(2);
        extreset = 1'b1;
        step(2);
        push(cyc + 1, 4'b0000, 0, 0, 0, "nolock_idle");
        step(2);

        // Scenario 1: both lock bits rise before edge 0
        b = cyc;
        pll_locked = 2'b11;
        push(b + 6,  4'b0000, 0, 0, 0, "s1_filter");
        push(b + 7,  4'b0000, 0, 1, 0, "s1_release");
        push(b + 14, 4'b0000, 0, 1, 0, "s1_pre_d0");
        push(b + 15, 4'b0001, 0, 1, 0, "s1_d0");
        push(b + 23, 4'b0011, 0, 1, 0, "s1_d1");
        push(b + 31, 4'b0111, 0, 1, 0, "s1_d2");
        push(b + 38, 4'b0111, 0, 1, 0, "s1_pre_d3");
        push(b + 39, 4'b1111, 0, 2, 0, "s1_run");
        push(b + 40, 4'b1111, 1, 2, 0, "s1_ready");
        wait_until(b + 42);

        // Scenario 4: soft reset in RUN, second request during DRAIN ignored
        b = cyc;
        push(b + 1,  4'b0000, 0, 3, 0, "s4_drain");
        push(b + 5,  4'b0000, 0, 3, 0, "s4_drain_hold");
        push(b + 8,  4'b0000, 0, 3, 0, "s4_drain_last");
        push(b + 9,  4'b0000, 0, 0, 0, "s4_wait");
        push(b + 13, 4'b0000, 0, 0, 0, "s4_filter");
        push(b + 14, 4'b0000, 0, 1, 0, "s4_release");
        push(b + 22, 4'b0001, 0, 1, 0, "s4_d0");
        push(b + 45, 4'b0111, 0, 1, 0, "s4_pre_run");
        push(b + 46, 4'b1111, 0, 2, 0, "s4_run");
        push(b + 47, 4'b1111, 1, 2, 0, "s4_ready");
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        step(3);
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        wait_until(b + 49);

        // Scenario 3: one lock bit drops for one cycle in RUN
        b = cyc;
        push(b + 2,  4'b1111, 1, 2, 0, "s3_sync_delay");
        push(b + 3,  4'b0000, 0, 0, 1, "s3_lost");
        push(b + 7,  4'b0000, 0, 0, 1, "s3_filter");
        push(b + 8,  4'b0000, 0, 1, 1, "s3_release");
        push(b + 40, 4'b1111, 0, 2, 1, "s3_run");
        push(b + 41, 4'b1111, 1, 2, 1, "s3_ready");
        pll_locked = 2'b10;
        step(1);
        pll_locked = 2'b11;
        wait_until(b + 43);

        // Scenario 5: lock loss and soft reset together in RELEASE
        b = cyc;
        push(b + 3,  4'b0000, 0, 0, 2, "s5_lost_run");
        push(b + 8,  4'b0000, 0, 1, 2, "s5_release");
        push(b + 12, 4'b0000, 0, 1, 2, "s5_pre_both");
        push(b + 13, 4'b0000, 0, 0, 3, "s5_lock_wins");
        push(b + 14, 4'b0000, 0, 0, 3, "s5_no_drain");
        push(b + 17, 4'b0000, 0, 0, 3, "s5_filter");
        push(b + 18, 4'b0000, 0, 1, 3, "s5_release2");
        push(b + 27, 4'b0001, 0, 1, 3, "s5_d0");
        push(b + 29, 4'b0000, 0, 0, 0, "async_reset");
        pll_locked = 2'b10;
        step(1);
        pll_locked = 2'b11;
        wait_until(b + 10);
        pll_locked = 2'b10;
        step(1);
        pll_locked = 2'b11;
        step(1);
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;

        // Async reset mid-RELEASE, asserted just after a rising edge
        wait_until(b + 28);
        @(posedge clk);
        #2 extreset = 1'b0;
        step(2);
        extreset = 1'b1;

        // Scenario 2: one-cycle lock glitch during the WAIT_LOCK filter
        c = cyc;
        push(c + 7,  4'b0000, 0, 0, 0, "s2_filter_restart");
        push(c + 10, 4'b0000, 0, 0, 0, "s2_filter");
        push(c + 11, 4'b0000, 0, 1, 0, "s2_release");
        push(c + 19, 4'b0001, 0, 1, 0, "s2_d0");
        push(c + 43, 4'b1111, 0, 2, 0, "s2_run");
        push(c + 44, 4'b1111, 1, 2, 0, "s2_ready");
        step(3);
        pll_locked = 2'b01;
        step(1);
        pll_locked = 2'b11;
        wait_until(c + 46);

        // Scenario 3b: 300 drop/re-lock cycles, count saturates at 255
        for (int i = 0; i < 300; i++) begin
            d = cyc;
            pll_locked = 2'b10;
            step(1);
            pll_locked = 2'b11;
            step(9);
            push(d + 11, 4'b0000, 0, 1, (i + 1 > 255) ? 8'd255 : 8'(i + 1), "sat_count");
        end

        // Final RUN: watchdog fires only when built in
        e = cyc;
        push(e + 29, 4'b0111, 0, 1, 255, "fin_pre_run");
        push(e + 30, 4'b1111, 0, 2, 255, "fin_run");
        push(e + 31, 4'b1111, 1, 2, 255, "fin_ready");
`ifdef HL_RESET_WDOG_EN
        push(e + 93,  4'b1111, 1, 2, 255, "wdog_pre_fire", 1'b0);
        push(e + 94,  4'b0000, 0, 3, 255, "wdog_fire", 1'b1);
        push(e + 102, 4'b0000, 0, 0, 255, "wdog_sticky", 1'b1);
`else
        push(e + 100, 4'b1111, 1, 2, 255, "no_wdog");
`endif
        wait_until(e + 104);

        step(3);
        if (sbq.size() != 0) begin
            failures += sbq.size();
            $display("FAIL scoreboard_drain: pending=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
